decode: RTL and testbench
=========================

// Module: decode
// PURPOSE
//  Decode stage directly downstream of the two-stage fetch. Consumes the fetch bubble/PC pair
//  and the instruction word returned by memory, reads the register file and extracts fields.
//  Detects load-use hazards and registers decoded operands toward execute. Holds the
//  instruction word across downstream stalls, because memory re-fetches during a stall.
// PARAMETERS
//  NREGS    32  architectural registers; r0 always reads 0
//  IMM_W    17  immediate field width, sign-extended to 32
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous active-high reset
//  stall        in   1   downstream stall; hold all decode state
//  flush        in   1   branch taken in execute; kill the instruction in decode
//  bubble_in    in   1   fetch_b bubble flag
//  pc_in        in   32  fetch_b PC
//  mem_data     in   32  instruction word for pc_in (valid the same cycle)
//  ex_is_load   in   1   execute holds a load
//  ex_bubble    in   1   execute holds a bubble
//  ex_rd        in   5   execute destination register
//  wb_en        in   1   writeback enable
//  wb_addr      in   5   writeback register
//  wb_data      in   32  writeback value
//  stall_out    out  1   stall to fetch: stall | load-use hazard
//  bubble_out   out  1   registered bubble toward execute
//  pc_out       out  32  registered PC
//  opcode_out   out  5   instr[31:27]
//  rd_out       out  5   instr[26:22]
//  ra_val       out  32  regfile[instr[21:17]]
//  rb_val       out  32  regfile[instr[4:0]]
//  imm_out      out  32  sign-extended instr[16:0]
// BEHAVIOUR
//  - Reset (sync): bubble_out=1; pc_out, opcode_out, rd_out, ra_val, rb_val, imm_out=0;
//    hold_valid=0. Regfile contents are not reset.
//  - Instruction select: instr = hold_valid ? ir_hold : mem_data.
//  - Hold register: when stall && !hold_valid && !bubble_in, capture mem_data; set hold_valid.
//    When !stall, clear hold_valid. When flush or rst, clear hold_valid.
//  - Hazard: haz = ex_is_load & !ex_bubble & ex_rd!=0 & !bubble_in
//    & (ex_rd==instr[21:17] | ex_rd==instr[4:0]). stall_out = stall | haz (combinational).
//  - Pipeline register update at posedge, in priority order:
//    1. rst: reset values.
//    2. stall: all outputs hold.
//    3. flush: bubble_out<=1.
//    4. haz: bubble_out<=1. The instruction stays in decode via stall_out; hold register captures it.
//    5. Otherwise: bubble_out<=bubble_in; all fields latched. Latency is 1 cycle from fetch_b.
//  - Simultaneous stall & flush: stall wins; the flush is re-presented by execute.
//  - Regfile: writes on posedge when wb_en & wb_addr!=0. Reads are combinational. r0 is constant 0.
//  - Same-cycle write/read of the same register: result depends on config (below).
// CONFIGURATION
//  - REGFILE_BYPASS_EN defined: a read whose address equals wb_addr (wb_en, addr!=0) returns wb_data.
//  - REGFILE_BYPASS_EN undefined: the read returns the old value.
//    Execute must then forward from writeback itself.
// STRUCTURE
//  - Shared package (cpu_pkg): opcode localparams, field bit-position constants,
//    REG_W=5, XLEN=32, and a decoded-fields struct/typedef.
//  - One sub-module: regfile (2 async read ports, 1 sync write port, bypass macro inside).
//  - Hazard logic and hold register stay inline in decode.
// TESTING
//  1. rst=1 for 2 cycles -> bubble_out=1, pc_out=0, stall_out=0; release with bubble_in=1 -> bubble_out stays 1.
//  2. bubble_in=0, pc_in=0x10, mem_data=0x08C4_0005 (op 1, rd 3, ra 2, rb 5); r2=7, r5=9 ->
//     next cycle pc_out=0x10, opcode_out=1, rd_out=3, ra_val=7, rb_val=9, imm_out=0x00000005.
//  3. Sign extension: instr[16:0]=0x1FFFF -> imm_out=0xFFFFFFFF.
//  4. Stall for 3 cycles while mem_data changes to 0xDEAD_BEEF -> outputs frozen.
//     On release, decode emits the originally captured word, not 0xDEADBEEF.
//  5. Load-use: ex_is_load=1, ex_bubble=0, ex_rd=2, decode instr reads r2 ->
//     stall_out=1, bubble_out=1 next cycle. When ex_bubble=1, the same instruction issues.
//     Repeat with ex_rd=0 -> no stall.
//  6. flush with a valid instr -> bubble_out=1 next cycle. wb_en, wb_addr=0, wb_data=5 -> r0 reads 0.
//     wb to r4 with a same-cycle read of r4 -> new value if REGFILE_BYPASS_EN, else old value.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants, instruction field positions and the decoded-field bundle.
// Used by decode and its regfile; the build option REGFILE_BYPASS_EN lives in regfile.
package cpu_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam int NREGS = 32;
  localparam int IMM_W = 17;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 22;
  localparam int RA_HI  = 21;
  localparam int RA_LO  = 17;
  localparam int RB_HI  = 4;
  localparam int RB_LO  = 0;
  localparam int IMM_HI = IMM_W - 1;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_ADDI = 5'd2;
  localparam logic [4:0] OP_LD   = 5'd3;
  localparam logic [4:0] OP_ST   = 5'd4;
  localparam logic [4:0] OP_BEQ  = 5'd5;

  typedef struct packed {
    logic [4:0]       opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [XLEN-1:0]  imm;
  } dec_t;

  function automatic dec_t split(input logic [XLEN-1:0] w);
    dec_t d;
    d.opcode = w[OP_HI:OP_LO];
    d.rd     = w[RD_HI:RD_LO];
    d.ra     = w[RA_HI:RA_LO];
    d.rb     = w[RB_HI:RB_LO];
    d.imm    = {{(XLEN-IMM_W){w[IMM_HI]}}, w[IMM_HI:0]};
    return d;
  endfunction

endpackage

// File: rtl/decode_if.sv
// Decode stage bundle: fetch inputs, execute/writeback feedback, outputs to execute.
// master drives the inputs, slave is the decode stage.
interface decode_if;
  import cpu_pkg::*;

  logic             stall;
  logic             flush;
  logic             bubble_in;
  logic [XLEN-1:0]  pc_in;
  logic [XLEN-1:0]  mem_data;
  logic             ex_is_load;
  logic             ex_bubble;
  logic [REG_W-1:0] ex_rd;
  logic             wb_en;
  logic [REG_W-1:0] wb_addr;
  logic [XLEN-1:0]  wb_data;
  logic             stall_out;
  logic             bubble_out;
  logic [XLEN-1:0]  pc_out;
  logic [4:0]       opcode_out;
  logic [REG_W-1:0] rd_out;
  logic [XLEN-1:0]  ra_val;
  logic [XLEN-1:0]  rb_val;
  logic [XLEN-1:0]  imm_out;

  modport master (
    output stall, flush, bubble_in, pc_in, mem_data,
    output ex_is_load, ex_bubble, ex_rd,
    output wb_en, wb_addr, wb_data,
    input  stall_out, bubble_out, pc_out, opcode_out,
    input  rd_out, ra_val, rb_val, imm_out
  );

  modport slave (
    input  stall, flush, bubble_in, pc_in, mem_data,
    input  ex_is_load, ex_bubble, ex_rd,
    input  wb_en, wb_addr, wb_data,
    output stall_out, bubble_out, pc_out, opcode_out,
    output rd_out, ra_val, rb_val, imm_out
  );

endinterface

// File: rtl/decode_regfile.sv
// 2R/1W register file, r0 hardwired to zero.
// REGFILE_BYPASS_EN: a read matching the live write returns the write data.
module regfile
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [REG_W-1:0] wa,
  input  logic [XLEN-1:0]  wd,
  input  logic [REG_W-1:0] ra_addr,
  input  logic [REG_W-1:0] rb_addr,
  output logic [XLEN-1:0]  ra_data,
  output logic [XLEN-1:0]  rb_data
);

  logic [XLEN-1:0] mem [NREGS];
  logic            wr;

  assign wr = we && (wa != '0);

  always_ff @(posedge clk) begin
    if (wr) mem[wa] <= wd;
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    ra_data = '0;
    rb_data = '0;
    if (ra_addr != '0) ra_data = (wr && wa == ra_addr) ? wd : mem[ra_addr];
    if (rb_addr != '0) rb_data = (wr && wa == rb_addr) ? wd : mem[rb_addr];
  end
`else
  always_comb begin
    ra_data = '0;
    rb_data = '0;
    if (ra_addr != '0) ra_data = mem[ra_addr];
    if (rb_addr != '0) rb_data = mem[rb_addr];
  end
`endif

endmodule

// File: rtl/decode.sv
// Decode stage: field extraction, regfile read, load-use detection, stall hold.
// Build option REGFILE_BYPASS_EN selects write-through reads in the regfile.
module decode
  import cpu_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  decode_if.slave  bus
);

  logic            hold_valid;
  logic [XLEN-1:0] ir_hold;
  logic [XLEN-1:0] instr;
  dec_t            f;
  logic            haz;
  logic            stall_all;
  logic [XLEN-1:0] ra_rd;
  logic [XLEN-1:0] rb_rd;

  assign instr = hold_valid ? ir_hold : bus.mem_data;
  assign f     = split(instr);

  assign haz = bus.ex_is_load && !bus.ex_bubble
            && (bus.ex_rd != '0) && !bus.bubble_in
            && ((bus.ex_rd == f.ra) || (bus.ex_rd == f.rb));

  assign stall_all     = bus.stall || haz;
  assign bus.stall_out = stall_all;

  regfile u_rf (
    .clk     (clk),
    .we      (bus.wb_en),
    .wa      (bus.wb_addr),
    .wd      (bus.wb_data),
    .ra_addr (f.ra),
    .rb_addr (f.rb),
    .ra_data (ra_rd),
    .rb_data (rb_rd)
  );

  // memory re-fetches while fetch is stalled, so keep the first word seen
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      hold_valid <= 1'b0;
    end else if (!stall_all) begin
      hold_valid <= 1'b0;
    end else if (!hold_valid && !bus.bubble_in) begin
      hold_valid <= 1'b1;
      ir_hold    <= bus.mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.bubble_out <= 1'b1;
      bus.pc_out     <= '0;
      bus.opcode_out <= '0;
      bus.rd_out     <= '0;
      bus.ra_val     <= '0;
      bus.rb_val     <= '0;
      bus.imm_out    <= '0;
    end else if (bus.stall) begin
      bus.bubble_out <= bus.bubble_out;
    end else if (bus.flush || haz) begin
      bus.bubble_out <= 1'b1;
    end else begin
      bus.bubble_out <= bus.bubble_in;
      bus.pc_out     <= bus.pc_in;
      bus.opcode_out <= f.opcode;
      bus.rd_out     <= f.rd;
      bus.ra_val     <= ra_rd;
      bus.rb_val     <= rb_rd;
      bus.imm_out    <= f.imm;
    end
  end

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: expected records queued at drive time,
// popped and compared when the stage issues.
module tb_decode;
  import cpu_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] op;
    logic [31:0] rd;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] imm;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t last;
  logic [31:0] rf_m [32];

  decode_if bus ();

  decode u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] ra, input logic [11:0] mid,
                                      input logic [4:0] rb);
    return {op, rd, ra, mid, rb};
  endfunction

  function automatic logic [31:0] rd_m(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : rf_m[a];
  endfunction

  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] w);
    exp_t e;
    e.pc  = pc;
    e.op  = 32'(w[31:27]);
    e.rd  = 32'(w[26:22]);
    e.ra  = rd_m(w[21:17]);
    e.rb  = rd_m(w[4:0]);
    e.imm = {{15{w[16]}}, w[16:0]};
    return e;
  endfunction

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_en   = 1'b1;
    bus.wb_addr = a;
    bus.wb_data = d;
    step();
    if (a != 5'd0) rf_m[a] = d;
    bus.wb_en   = 1'b0;
  endtask

  task automatic cmp_out(input string tag, input exp_t e);
    check({tag, ".pc"},  bus.pc_out, e.pc);
    check({tag, ".op"},  32'(bus.opcode_out), e.op);
    check({tag, ".rd"},  32'(bus.rd_out), e.rd);
    check({tag, ".ra"},  bus.ra_val, e.ra);
    check({tag, ".rb"},  bus.rb_val, e.rb);
    check({tag, ".imm"}, bus.imm_out, e.imm);
  endtask

  task automatic expect_out(input string tag);
    check({tag, ".bub"}, 32'(bus.bubble_out), 32'd0);
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      last = sb.pop_front();
      cmp_out(tag, last);
    end
  endtask

  task automatic issue(input string tag, input logic [31:0] pc,
                       input logic [31:0] w);
    bus.bubble_in = 1'b0;
    bus.pc_in     = pc;
    bus.mem_data  = w;
    sb.push_back(model(pc, w));
    step();
    expect_out(tag);
    bus.bubble_in = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    exp_t e;
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    rst            = 1'b1;
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
    bus.bubble_in  = 1'b1;
    bus.pc_in      = '0;
    bus.mem_data   = '0;
    bus.ex_is_load = 1'b0;
    bus.ex_bubble  = 1'b1;
    bus.ex_rd      = '0;
    bus.wb_en      = 1'b0;
    bus.wb_addr    = '0;
    bus.wb_data    = '0;
    step();
    step();
    check("rst.bub",   32'(bus.bubble_out), 32'd1);
    check("rst.pc",    bus.pc_out, 32'd0);
    check("rst.stall", 32'(bus.stall_out), 32'd0);
    check("rst.imm",   bus.imm_out, 32'd0);
    rst = 1'b0;
    step();
    check("idle.bub", 32'(bus.bubble_out), 32'd1);

    wb(5'd2, 32'd7);
    wb(5'd5, 32'd9);
    wb(5'd4, 32'h44);
    wb(5'd1, 32'h11);
    wb(5'd31, 32'hAAAA_0031);

    issue("basic", 32'h10, 32'h08C4_0005);
    check("basic.op_lit", 32'(bus.opcode_out), 32'(OP_ADD));
    check("basic.ra_lit", bus.ra_val, 32'd7);

    issue("sext", 32'h14, enc(OP_ADDI, 5'd1, 5'd1, 12'hFFF, 5'h1F));
    check("sext.imm_lit", bus.imm_out, 32'hFFFF_FFFF);

    // stall: the first word is held while memory shows something else
    w = enc(OP_LD, 5'd7, 5'd4, 12'h012, 5'd1);
    bus.stall     = 1'b1;
    bus.bubble_in = 1'b0;
    bus.pc_in     = 32'h18;
    bus.mem_data  = w;
    sb.push_back(model(32'h18, w));
    for (int i = 0; i < 3; i++) begin
      step();
      bus.mem_data = 32'hDEAD_BEEF;
      #1;
      check("stall.out", 32'(bus.stall_out), 32'd1);
      check("stall.bub", 32'(bus.bubble_out), 32'd0);
      cmp_out("frozen", last);
    end
    bus.stall = 1'b0;
    step();
    expect_out("release");
    bus.bubble_in = 1'b1;
    bus.mem_data  = '0;

    // load-use on ra
    bus.ex_is_load = 1'b1;
    bus.ex_bubble  = 1'b0;
    bus.ex_rd      = 5'd2;
    bus.bubble_in  = 1'b0;
    bus.pc_in      = 32'h1C;
    bus.mem_data   = 32'h08C4_0005;
    #1;
    check("lu.stall", 32'(bus.stall_out), 32'd1);
    step();
    check("lu.bub", 32'(bus.bubble_out), 32'd1);
    check("lu.stall2", 32'(bus.stall_out), 32'd1);
    bus.ex_bubble = 1'b1;
    #1;
    check("lu.clear", 32'(bus.stall_out), 32'd0);
    bus.bubble_in = 1'b1;
    issue("lu.issue", 32'h1C, 32'h08C4_0005);

    // load-use on rb
    bus.ex_bubble = 1'b0;
    bus.ex_rd     = 5'd5;
    bus.bubble_in = 1'b0;
    bus.pc_in     = 32'h20;
    bus.mem_data  = 32'h08C4_0005;
    #1;
    check("lu_rb.stall", 32'(bus.stall_out), 32'd1);
    bus.bubble_in = 1'b1;
    #1;
    check("lu_rb.bubin", 32'(bus.stall_out), 32'd0);

    // ex_rd = r0 never stalls, even when decode reads r0
    bus.ex_rd     = 5'd0;
    bus.bubble_in = 1'b0;
    bus.mem_data  = enc(OP_ST, 5'd6, 5'd0, 12'h003, 5'd0);
    #1;
    check("lu_r0.stall", 32'(bus.stall_out), 32'd0);
    issue("lu_r0", 32'h24, enc(OP_ST, 5'd6, 5'd0, 12'h003, 5'd0));
    bus.ex_is_load = 1'b0;
    bus.ex_bubble  = 1'b1;

    // flush kills the instruction in decode
    bus.flush     = 1'b1;
    bus.bubble_in = 1'b0;
    bus.pc_in     = 32'h28;
    bus.mem_data  = 32'h08C4_0005;
    step();
    check("flush.bub", 32'(bus.bubble_out), 32'd1);
    bus.flush     = 1'b0;
    bus.bubble_in = 1'b1;

    wb(5'd0, 32'd5);
    issue("r0", 32'h2C, enc(OP_BEQ, 5'd0, 5'd0, 12'h000, 5'd0));
    check("r0.ra_lit", bus.ra_val, 32'd0);

    // write r4 while decode reads it
    w = enc(OP_ADD, 5'd8, 5'd4, 12'h000, 5'd1);
    e = model(32'h30, w);
`ifdef REGFILE_BYPASS_EN
    e.ra = 32'h1234;
`endif
    bus.wb_en     = 1'b1;
    bus.wb_addr   = 5'd4;
    bus.wb_data   = 32'h1234;
    bus.bubble_in = 1'b0;
    bus.pc_in     = 32'h30;
    bus.mem_data  = w;
    sb.push_back(e);
    step();
    rf_m[4]     = 32'h1234;
    bus.wb_en   = 1'b0;
    expect_out("byp");
    bus.bubble_in = 1'b1;
    issue("r4_after", 32'h34, w);

    check("sb.drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
